imem_boot_loader: RTL and testbench

- Boot sequencer for the 5-stage RV32I core.
- Holds the core in reset and streams program words from a host into the byte-wide instruction RAM, big-endian byte order.
- Then releases the core and lets it run for a programmed number of cycles before freezing it via mem_en.
- Arbitrates the instruction-RAM address port: the loader owns it while loading, core fetch owns it while running.

---
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer: streams host words into the byte-wide
// instruction RAM while the core is held in reset, then runs the core for a bounded time.
module imem_boot_loader #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_WORDS     = 256,
  parameter int RELEASE_DELAY = 2,
  parameter int RUN_WIDTH     = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  input  logic [RUN_WIDTH-1:0]           run_limit,
  input  logic                           in_valid,
  input  logic [31:0]                    in_data,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          fetch_addr,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [7:0]                     ram_wdata,
  output logic                           core_reset,
  output logic                           core_mem_en,
  output logic                           busy,
  output logic                           done,
  output logic                           load_error
);

  localparam int CW = $clog2(MAX_WORDS+1);
  localparam int HW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RELEASE_DELAY-1);
  localparam logic [CW-1:0]        MAX_CNT   = CW'(MAX_WORDS);
  localparam logic [RUN_WIDTH-1:0] RUN_MAX   = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  logic [2:0]            state;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [23:0]           shift_q;
  logic [1:0]            byte_idx;
  logic [CW-1:0]         word_idx;
  logic [CW-1:0]         count_q;
  logic [RUN_WIDTH-1:0]  limit_q;
  logic [HW-1:0]         hold_cnt;
  logic [RUN_WIDTH-1:0]  run_cnt;
  logic [RUN_WIDTH-1:0]  run_next;
  logic                  fetch_phase;

  assign run_next    = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_WIDTH'(1);
  assign fetch_phase = (state == RUN) || (state == HALT);

  // Core fetch owns the RAM address port once the core has been released.
  assign ram_addr = fetch_phase ? fetch_addr : load_addr;
  assign ram_we   = load_we & ~fetch_phase;
  assign busy     = (state != IDLE) && (state != HALT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      load_we     <= 1'b0;
      load_addr   <= '0;
      ram_wdata   <= 8'h00;
      shift_q     <= '0;
      byte_idx    <= 2'd0;
      word_idx    <= '0;
      count_q     <= '0;
      limit_q     <= '0;
      hold_cnt    <= '0;
      run_cnt     <= '0;
      core_reset  <= 1'b1;
      core_mem_en <= 1'b0;
      done        <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            if (word_count == '0 || word_count > MAX_CNT) begin
              load_error <= 1'b1;
            end else begin
              load_error  <= 1'b0;
              done        <= 1'b0;
              core_reset  <= 1'b1;
              core_mem_en <= 1'b0;
              count_q     <= word_count;
              limit_q     <= run_limit;
              word_idx    <= '0;
              load_addr   <= '0;
              in_ready    <= 1'b1;
              state       <= WAIT;
            end
          end
        end

        WAIT: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            load_we   <= 1'b1;
            ram_wdata <= in_data[31:24];
            shift_q   <= in_data[23:0];
            byte_idx  <= 2'd0;
            state     <= WRITE;
          end
        end

        WRITE: begin
          // load_addr walks straight through to the next word's base address.
          load_addr <= load_addr + ADDR_WIDTH'(1);
          byte_idx  <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            load_we  <= 1'b0;
            word_idx <= word_idx + CW'(1);
            if (word_idx + CW'(1) == count_q) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              in_ready <= 1'b1;
              state    <= WAIT;
            end
          end else begin
            ram_wdata <= shift_q[23:16];
            shift_q   <= {shift_q[15:0], 8'h00};
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            core_reset  <= 1'b0;
            core_mem_en <= 1'b1;
            run_cnt     <= '0;
            state       <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        RUN: begin
          run_cnt <= run_next;
          if (limit_q != '0 && run_next == limit_q) begin
            core_mem_en <= 1'b0;
            done        <= 1'b1;
            state       <= HALT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

  localparam int RD = 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic [8:0]  word_count;
  logic [15:0] run_limit;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [9:0]  fetch_addr;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        core_reset;
  logic        core_mem_en;
  logic        busy;
  logic        done;
  logic        load_error;

  imem_boot_loader #(
    .ADDR_WIDTH(10), .MAX_WORDS(256), .RELEASE_DELAY(RD), .RUN_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .run_limit(run_limit), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .core_reset(core_reset),
    .core_mem_en(core_mem_en), .busy(busy), .done(done), .load_error(load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [0:3] = '{32'h00000000, 32'h00300213, 32'h07ff00b7, 32'hff800167};
  logic [7:0]  exp_bytes [0:15] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h02, 8'h13,
                                    8'h07, 8'hff, 8'h00, 8'hb7, 8'hff, 8'h80, 8'h01, 8'h67};

  // RAM model and activity counters, sampled on the falling edge.
  logic [7:0] mem [0:1023];
  int  cyc = 0, we_total = 0, last_we = 0, fall_cyc = 0, en_total = 0;
  logic prev_cr = 1'b1;
  bit   mem_clr = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (mem_clr) for (int i = 0; i < 1024; i++) mem[i] = 8'haa;
    if (ram_we) begin
      mem[ram_addr] = ram_wdata;
      we_total++;
      last_we = cyc;
    end
    if (core_mem_en) en_total++;
    if (prev_cr && !core_reset) fall_cyc = cyc;
    prev_cr = core_reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int cnt, input int lim);
    @(negedge clock);
    start = 1'b1;
    word_count = 9'(cnt);
    run_limit = 16'(lim);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t == 50) check("ready_timeout", in_ready, 1);
  endtask

  task automatic wait_run();
    int t = 0;
    while (!core_mem_en && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t == 100) check("run_timeout", core_mem_en, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t == 300) check("done_timeout", done, 1);
  endtask

  task automatic feed(input int n, input int stall_before);
    for (int i = 0; i < n; i++) begin
      if (i == stall_before) begin
        in_valid = 1'b0;
        wait_ready();
        for (int k = 0; k < 3; k++) begin
          check("stall_ready", in_ready, 1);
          check("stall_we", ram_we, 0);
          @(negedge clock);
        end
      end
      in_data  = prog[i];
      in_valid = 1'b1;
      wait_ready();
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(negedge clock);
    #1 mem_clr = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++)
      check($sformatf("%s_byte%0d", tag, a), mem[a], exp_bytes[a]);
  endtask

  int base_we, base_en;

  initial begin
    reset = 1'b0; start = 1'b0; word_count = '0; run_limit = '0;
    in_valid = 1'b0; in_data = '0; fetch_addr = '0;

    @(negedge clock);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_mem_en", core_mem_en, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", load_error, 0);
    reset = 1'b1;
    clear_mem();

    // Full load with run_limit=80, valid held high.
    base_we = we_total;
    base_en = en_total;
    do_start(4, 80);
    check("s1_ready", in_ready, 1);
    check("s1_busy", busy, 1);
    feed(4, -1);
    wait_run();
    #1;
    check("s1_we_count", we_total - base_we, 16);
    // HOLD lasts RD cycles, so core_reset is first seen low RD+1 edges after the last write.
    check("s1_release", fall_cyc - last_we, RD + 1);
    check_mem("s1");
    wait_done();
    #1;
    check("s3_run_cycles", en_total - base_en, 80);
    check("s3_done", done, 1);
    check("s3_mem_en", core_mem_en, 0);
    check("s3_core_reset", core_reset, 0);
    check("s3_busy", busy, 0);
    fetch_addr = 10'h155;
    #1;
    check("s3_fetch_pass", ram_addr, 10'h155);
    check("s3_halt_we", ram_we, 0);

    // Restart from HALT with a host stall, unlimited run.
    clear_mem();
    base_we = we_total;
    do_start(4, 0);
    check("s6_halt_core_reset", core_reset, 1);
    check("s6_halt_done", done, 0);
    feed(4, 2);
    wait_run();
    #1;
    check("s2_we_count", we_total - base_we, 16);
    check_mem("s2");
    base_en = en_total;
    repeat (1000) @(negedge clock);
    #1;
    check("s3_unlim_done", done, 0);
    check("s3_unlim_en", core_mem_en, 1);
    check("s3_unlim_cycles", en_total - base_en, 1000);

    // Start while running is ignored.
    do_start(4, 80);
    repeat (3) @(negedge clock);
    check("s6_run_mem_en", core_mem_en, 1);
    check("s6_run_core_reset", core_reset, 0);
    check("s6_run_ready", in_ready, 0);

    // Rejected starts from IDLE.
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    #1 base_we = we_total;
    do_start(0, 0);
    check("s4_err0", load_error, 1);
    check("s4_busy0", busy, 0);
    check("s4_core_reset0", core_reset, 1);
    do_start(257, 0);
    check("s4_err257", load_error, 1);
    check("s4_busy257", busy, 0);
    repeat (5) @(negedge clock);
    #1;
    check("s4_no_we", we_total - base_we, 0);
    check("s4_core_reset", core_reset, 1);

    // Reset during byte 2 of word 1.
    do_start(4, 20);
    check("s5_err_clear", load_error, 0);
    in_data = prog[0];
    in_valid = 1'b1;
    wait_ready();
    @(negedge clock);
    in_data = prog[1];
    wait_ready();
    repeat (3) @(negedge clock);
    check("s5_pre_we", ram_we, 1);
    check("s5_pre_addr", ram_addr, 6);
    check("s5_pre_wdata", ram_wdata, 8'h02);
    #1 reset = 1'b0;
    #1;
    check("s5_we", ram_we, 0);
    check("s5_addr", ram_addr, 0);
    check("s5_wdata", ram_wdata, 0);
    check("s5_core_reset", core_reset, 1);
    check("s5_mem_en", core_mem_en, 0);
    check("s5_ready", in_ready, 0);
    check("s5_busy", busy, 0);
    in_valid = 1'b0;
    @(negedge clock) reset = 1'b1;
    #1 base_we = we_total;
    repeat (10) @(negedge clock);
    #1;
    check("s5_no_we", we_total - base_we, 0);

    clear_mem();
    base_we = we_total;
    do_start(4, 0);
    feed(4, -1);
    wait_run();
    #1;
    check("s5_reload_we", we_total - base_we, 16);
    check_mem("s5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
